// File: rtl/float_unit_pkg.sv
// Shared definitions for the float streaming units: FSM state encoding and
// the single-precision NaN detector.
package float_unit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 32 - 1 - EXP_W;

    // NaN: exponent all ones with a nonzero fraction (infinity is not NaN).
    function automatic logic is_nan(input logic [31:0] word);
        return (&word[30 -: EXP_W]) && (|word[FRAC_W-1:0]);
    endfunction

endpackage

// File: rtl/float_run_delay.sv
// Start sequencer: after a run pulse, waits the configured number of cycles
// and then emits a one-cycle start_accum pulse.
module float_run_delay
    import float_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             running,
    input  logic             run,
    input  logic [CNT_W-1:0] delay,
    output logic             start_accum
);

    logic [CNT_W-1:0] delay_cnt;
    logic             waiting;

    // A zero delay starts in the run cycle itself; otherwise start when the count hits 1.
    assign start_accum = running && (run ? (delay == '0)
                                         : (waiting && (delay_cnt == CNT_W'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt <= '0;
            waiting   <= 1'b0;
        end else if (running) begin
            if (run) begin
                delay_cnt <= delay;
                waiting   <= (delay != '0);
            end else if (waiting) begin
                delay_cnt <= delay_cnt - CNT_W'(1);
                if (delay_cnt == CNT_W'(1))
                    waiting <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/float_select_accum.sv
// Streaming max/argmax accumulator fed by a float greater-equal comparator.
// Define FLOAT_SELECT_NAN_SKIP_EN to skip NaN candidates until a best exists.
module float_select_accum
    import float_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              running,
    input  logic              run,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  amount,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] out0,
    output logic [CNT_W-1:0]  out1,
    output logic              done
);

    logic [1:0]       state;
    logic [CNT_W-1:0] elem_cnt;
    logic             have_best;
    logic             start_accum;
    logic             take;
    logic             last_elem;
    logic             unused_mask_bits;

    float_run_delay #(.CNT_W(CNT_W)) u_run_delay (
        .clk         (clk),
        .rst_n       (rst_n),
        .running     (running),
        .run         (run),
        .delay       (delay),
        .start_accum (start_accum)
    );

    // The comparator mask is all-ones or all-zeros, so bit 0 carries it.
    assign unused_mask_bits = ^in1[DATA_W-1:1];
    assign last_elem        = (elem_cnt == amount - CNT_W'(1));
    assign done             = (state == ST_DONE);

    always_comb begin
`ifdef FLOAT_SELECT_NAN_SKIP_EN
        take = have_best ? in1[0] : !is_nan(in0[31:0]);
`else
        take = !have_best || in1[0];
`endif
    end

    // A run pulse restarts from any state; out0/out1 survive until the first take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            elem_cnt  <= '0;
            have_best <= 1'b0;
            out0      <= '0;
            out1      <= '0;
        end else if (running) begin
            if (run) begin
                elem_cnt  <= '0;
                have_best <= 1'b0;
                if (start_accum)
                    state <= (amount != '0) ? ST_ACCUM : ST_DONE;
                else
                    state <= ST_WAIT;
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (start_accum)
                            state <= (amount != '0) ? ST_ACCUM : ST_DONE;
                    end
                    ST_ACCUM: begin
                        if (take) begin
                            out0      <= in0;
                            out1      <= elem_cnt;
                            have_best <= 1'b1;
                        end
                        elem_cnt <= elem_cnt + CNT_W'(1);
                        if (last_elem)
                            state <= ST_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
